dnn_feature_packer: RTL

DNN_FEATURE_PACKER -- requirements
Module: dnn_feature_packer

---
 rtl/dnn_feature_packer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/dnn_feature_packer.sv
`default_nettype none
// ============================================================================
// Module      : dnn_feature_packer
// Description : Collects eight 12-bit features into a 128-bit classifier word,
//               waits RESULT_LAT enabled cycles, then hands off the yprd bit.
// Revision    : 1.0 - initial release
// ============================================================================
module dnn_feature_packer #(
    parameter int unsigned RESULT_LAT = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enb,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [11:0]  s_data,
    input  logic         s_sof,
    output logic [127:0] din_out,
    input  logic [7:0]   dout_in,
    output logic         m_valid,
    input  logic         m_ready,
    output logic         m_class,
    output logic         frame_err,
    output logic [15:0]  frame_cnt
);

    localparam int         c_NUM_LANES = 8;
    localparam logic [3:0] c_LAT       = 4'(RESULT_LAT);

    localparam logic [1:0] c_ST_COLLECT = 2'd0;
    localparam logic [1:0] c_ST_EVAL    = 2'd1;
    localparam logic [1:0] c_ST_OUTPUT  = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [2:0]  r_idx;
    logic [3:0]  r_cnt;
    logic [11:0] r_lane [c_NUM_LANES];
    logic        r_m_class;
    logic        r_frame_err;
    logic [15:0] r_frame_cnt;

    logic w_accept;
    logic w_restart;
    logic w_last;
    logic w_eval_done;
    logic w_handshake;

    assign w_accept    = enb & s_valid & (r_state == c_ST_COLLECT);
    // A start-of-frame mid-frame restarts at lane 0; it never completes a frame.
    assign w_restart   = w_accept & s_sof & (r_idx != 3'd0);
    assign w_last      = w_accept & ~w_restart & (r_idx == 3'd7);
    assign w_eval_done = enb & (r_state == c_ST_EVAL) & (r_cnt == 4'd0);
    assign w_handshake = enb & (r_state == c_ST_OUTPUT) & m_ready;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_COLLECT;
        end else if (enb) begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_COLLECT: if (w_last)      w_state_nxt = c_ST_EVAL;
            c_ST_EVAL:    if (w_eval_done) w_state_nxt = c_ST_OUTPUT;
            c_ST_OUTPUT:  if (w_handshake) w_state_nxt = c_ST_COLLECT;
            default:                       w_state_nxt = c_ST_COLLECT;
        endcase
    end

    // Output logic; s_ready is gated by reset so it drops the instant reset asserts.
    always_comb begin
        s_ready   = 1'b0;
        m_valid   = 1'b0;
        case (r_state)
            c_ST_COLLECT: s_ready = enb & ~reset;
            c_ST_OUTPUT:  m_valid = 1'b1;
            default:      ;
        endcase
        m_class   = r_m_class;
        frame_err = r_frame_err;
        frame_cnt = r_frame_cnt;
    end

    // Datapath: lane storage, index, wait counter, result capture, frame count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_NUM_LANES; i++) begin
                r_lane[i] <= 12'd0;
            end
            r_idx       <= 3'd0;
            r_cnt       <= 4'd0;
            r_m_class   <= 1'b0;
            r_frame_err <= 1'b0;
            r_frame_cnt <= 16'd0;
        end else if (enb) begin
            r_frame_err <= w_restart;
            if (w_restart) begin
                r_lane[0] <= s_data;
                r_idx     <= 3'd1;
            end else if (w_accept) begin
                r_lane[r_idx] <= s_data;
                r_idx         <= r_idx + 3'd1;
            end
            if (w_last) begin
                r_cnt <= c_LAT;
            end else if ((r_state == c_ST_EVAL) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_eval_done) begin
                r_m_class <= dout_in[0];
            end
            if (w_handshake) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    generate
        for (genvar k = 0; k < c_NUM_LANES; k++) begin : g_lane
            assign din_out[16*k +: 16] = {4'd0, r_lane[k]};
        end
    endgenerate

endmodule
`default_nettype wire
